// File: rtl/data_mem_hs.sv
// Big-endian byte-addressed data memory with valid/ready request and a one-pulse response after LATENCY wait states.
// Busy (req_ready=0) from accept until the response cycle ends; misalignment trapping is enabled by DMEM_MISALIGN_TRAP_EN.
module data_mem_hs #(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int CNT_INIT_I = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [3:0] CNT_INIT = CNT_INIT_I[3:0];
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic              lat_we, lat_unsigned;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic [7:0] mem [DEPTH_BYTES];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (LATENCY == 0) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);

  // The response is formed on the edge entering RESP; with zero latency that is the
  // accept edge itself, so the live request is used instead of the latched copy.
  logic              enter_resp;
  logic              cur_we, cur_unsigned;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;

  assign enter_resp   = (state_d == RESP);
  assign cur_we       = req_ready ? req_we       : lat_we;
  assign cur_unsigned = req_ready ? req_unsigned : lat_unsigned;
  assign cur_size     = req_ready ? req_size     : lat_size;
  assign cur_addr     = req_ready ? req_addr     : lat_addr;
  assign cur_wdata    = req_ready ? req_wdata    : lat_wdata;

  logic [ADDR_W:0] span, last_byte;
  logic [IDX_W-1:0] idx, idx1, idx2, idx3;
  logic misalign, acc_err, sx;
  logic [31:0] load_data, acc_rdata;

  always_comb begin
    span = '0;
    case (cur_size)
      2'b01:   span[1:0] = 2'd1;
      2'b10:   span[1:0] = 2'd3;
      default: span[1:0] = 2'd0;
    endcase
    // Range check uses the raw address so an unaligned word near the top still faults.
    last_byte = {1'b0, cur_addr} + span;
    idx = cur_addr[IDX_W-1:0];
    if (cur_size == 2'b01)      idx[0]   = 1'b0;
    else if (cur_size == 2'b10) idx[1:0] = 2'b00;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((cur_size == 2'b01) && cur_addr[0]) ||
                    ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign idx1    = idx + IDX_W'(1);
  assign idx2    = idx + IDX_W'(2);
  assign idx3    = idx + IDX_W'(3);
  assign acc_err = (cur_size == 2'b11) || (last_byte >= DEPTH_L) || misalign;
  assign sx      = ~cur_unsigned;

  always_comb begin
    case (cur_size)
      2'b00:   load_data = {{24{sx & mem[idx][7]}}, mem[idx]};
      2'b01:   load_data = {{16{sx & mem[idx][7]}}, mem[idx], mem[idx1]};
      default: load_data = {mem[idx], mem[idx1], mem[idx2], mem[idx3]};
    endcase
    acc_rdata = (acc_err || cur_we) ? 32'd0 : load_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && cur_we && !acc_err) begin
      case (cur_size)
        2'b00: mem[idx] <= cur_wdata[7:0];
        2'b01: begin
          mem[idx]  <= cur_wdata[15:8];
          mem[idx1] <= cur_wdata[7:0];
        end
        2'b10: begin
          mem[idx]  <= cur_wdata[31:24];
          mem[idx1] <= cur_wdata[23:16];
          mem[idx2] <= cur_wdata[15:8];
          mem[idx3] <= cur_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'b00;
      lat_addr     <= '0;
      lat_wdata    <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_valid <= enter_resp;
      rsp_rdata <= enter_resp ? acc_rdata : 32'd0;
      rsp_err   <= enter_resp & acc_err;
      if (req_ready && req_valid) begin
        lat_we       <= req_we;
        lat_unsigned <= req_unsigned;
        lat_size     <= req_size;
        lat_addr     <= req_addr;
        lat_wdata    <= req_wdata;
      end
    end
  end

endmodule
